// File: rtl/mac_operand_feeder_if.sv
// Operand stream between the feeder and the MAC: two signed operands with
// valid/first/last framing and a ready back-pressure line.
interface mac_operand_feeder_if #(
    parameter int unsigned INPUT_BW = 8
);
    logic signed [INPUT_BW-1:0] ia_row_mem_data;
    logic signed [INPUT_BW-1:0] weight_row_mem_data;
    logic                       op_valid;
    logic                       op_first;
    logic                       op_last;
    logic                       mac_ready;

    modport master (
        output ia_row_mem_data,
        output weight_row_mem_data,
        output op_valid,
        output op_first,
        output op_last,
        input  mac_ready
    );

    modport slave (
        input  ia_row_mem_data,
        input  weight_row_mem_data,
        input  op_valid,
        input  op_first,
        input  op_last,
        output mac_ready
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: walks a convolution window (oc, oy, ox, ky, kx) over the
// activation and weight row memories (1-cycle read latency) and streams operand
// pairs to the MAC with valid/ready flow control and a 1-entry skid buffer.
// Optional feature macro: MAC_FEEDER_STALL_CNT_EN adds the stall_cnt output.
module mac_operand_feeder #(
    parameter int unsigned INPUT_BW = 8,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       done,
    input  logic [2:0]                 K,
    input  logic [5:0]                 IMG_H,
    input  logic [5:0]                 IMG_W,
    input  logic [7:0]                 OC,
    input  logic [2:0]                 STRIDE,
    output logic                       ia_rd_en,
    output logic [ADDR_W-1:0]          ia_rd_addr,
    input  logic signed [INPUT_BW-1:0] ia_rd_data,
    output logic                       wt_rd_en,
    output logic [ADDR_W-1:0]          wt_rd_addr,
    input  logic signed [INPUT_BW-1:0] wt_rd_data,
    output logic                       busy,
    output logic                       cfg_err,
    mac_operand_feeder_if.master       mac_if
`ifdef MAC_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t state_q;

    // Configuration captured on the accepted start
    logic [2:0] k_q, stride_q;
    logic [5:0] imgh_q, imgw_q, oh_q, ow_q;
    logic [7:0] oc_cfg_q;

    // Loop counters for the next read to issue
    logic [7:0] oc_cnt_q;
    logic [5:0] oy_q, ox_q;
    logic [2:0] ky_q, kx_q;

    logic done_q, cfg_err_q, busy_q;

    // Beat whose read was issued last cycle (its data is on rd_data now)
    logic pend_q, pend_first_q, pend_last_q, pend_final_q;

    // Skid entry holding a beat the MAC refused
    logic                       skid_full_q, skid_first_q, skid_last_q, skid_final_q;
    logic signed [INPUT_BW-1:0] skid_ia_q, skid_wt_q;

    logic        start_acc, cfg_bad, issue, accept, head_valid, head_final;
    logic        kx_last, ky_last, ox_last, oy_last, oc_last;
    logic        beat_first, beat_last, beat_final;
    logic [5:0]  h_span, w_span, div_s, oh_d, ow_d;
    logic [15:0] ia_addr_full, wt_addr_full;

    assign start_acc = (state_q == IDLE) && start;

    assign cfg_bad = (k_q == 3'd0) || (stride_q == 3'd0) || (oc_cfg_q == 8'd0) ||
                     ({3'b000, k_q} > imgh_q) || ({3'b000, k_q} > imgw_q);

    // Output-map size; divisor forced non-zero so a rejected config stays benign
    always_comb begin
        div_s  = {3'b000, (stride_q == 3'd0) ? 3'd1 : stride_q};
        h_span = imgh_q - {3'b000, k_q};
        w_span = imgw_q - {3'b000, k_q};
        oh_d   = h_span / div_s + 6'd1;
        ow_d   = w_span / div_s + 6'd1;
    end

    assign kx_last    = (kx_q == k_q - 3'd1);
    assign ky_last    = (ky_q == k_q - 3'd1);
    assign ox_last    = (ox_q == ow_q - 6'd1);
    assign oy_last    = (oy_q == oh_q - 6'd1);
    assign oc_last    = (oc_cnt_q == oc_cfg_q - 8'd1);
    assign beat_first = (ky_q == 3'd0) && (kx_q == 3'd0);
    assign beat_last  = ky_last && kx_last;
    assign beat_final = beat_last && ox_last && oy_last && oc_last;

    // Read addresses from the current loop indices
    always_comb begin
        ia_addr_full = (16'(oy_q) * 16'(stride_q) + 16'(ky_q)) * 16'(imgw_q) +
                       16'(ox_q) * 16'(stride_q) + 16'(kx_q);
        wt_addr_full = 16'(oc_cnt_q) * 16'(k_q) * 16'(k_q) +
                       16'(ky_q) * 16'(k_q) + 16'(kx_q);
    end

    assign head_valid = skid_full_q || pend_q;
    assign head_final = skid_full_q ? skid_final_q : pend_final_q;
    assign accept     = head_valid && mac_if.mac_ready;

    // A new read is safe only if whatever is in flight now is guaranteed to fit
    // in the skid entry next cycle: nothing held at all, or the MAC is taking
    // the head this cycle. Counting the pending read as occupancy keeps a
    // single skid entry sufficient for any mac_ready pattern.
    assign issue = (state_q == RUN) && ((!skid_full_q && !pend_q) || mac_if.mac_ready);

    // Control FSM with registered done/cfg_err/busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            stride_q  <= '0;
            imgh_q    <= '0;
            imgw_q    <= '0;
            oc_cfg_q  <= '0;
            oh_q      <= '0;
            ow_q      <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_q      <= K;
                        stride_q <= STRIDE;
                        imgh_q   <= IMG_H;
                        imgw_q   <= IMG_W;
                        oc_cfg_q <= OC;
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        done_q    <= 1'b1;
                        cfg_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        oh_q    <= oh_d;
                        ow_q    <= ow_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (issue && beat_final) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && head_final) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Loop counters: kx innermost, then ky, ox, oy, oc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oc_cnt_q <= '0;
            oy_q     <= '0;
            ox_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
        end else if (start_acc) begin
            oc_cnt_q <= '0;
            oy_q     <= '0;
            ox_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
        end else if (issue) begin
            if (!kx_last) begin
                kx_q <= kx_q + 3'd1;
            end else begin
                kx_q <= '0;
                if (!ky_last) begin
                    ky_q <= ky_q + 3'd1;
                end else begin
                    ky_q <= '0;
                    if (!ox_last) begin
                        ox_q <= ox_q + 6'd1;
                    end else begin
                        ox_q <= '0;
                        if (!oy_last) begin
                            oy_q <= oy_q + 6'd1;
                        end else begin
                            oy_q <= '0;
                            if (!oc_last) begin
                                oc_cnt_q <= oc_cnt_q + 8'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // In-flight read tag and skid capture of a refused beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_final_q <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_first_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_final_q <= 1'b0;
            skid_ia_q    <= '0;
            skid_wt_q    <= '0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                pend_first_q <= beat_first;
                pend_last_q  <= beat_last;
                pend_final_q <= beat_final;
            end
            if (skid_full_q) begin
                if (mac_if.mac_ready) begin
                    skid_full_q <= 1'b0;
                end
            end else if (pend_q && !mac_if.mac_ready) begin
                skid_full_q  <= 1'b1;
                skid_ia_q    <= ia_rd_data;
                skid_wt_q    <= wt_rd_data;
                skid_first_q <= pend_first_q;
                skid_last_q  <= pend_last_q;
                skid_final_q <= pend_final_q;
            end
        end
    end

    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = busy_q;
    assign ia_rd_en   = issue;
    assign wt_rd_en   = issue;
    assign ia_rd_addr = ADDR_W'(ia_addr_full);
    assign wt_rd_addr = ADDR_W'(wt_addr_full);

    assign mac_if.op_valid            = head_valid;
    assign mac_if.op_first            = skid_full_q ? skid_first_q : (pend_q && pend_first_q);
    assign mac_if.op_last             = skid_full_q ? skid_last_q  : (pend_q && pend_last_q);
    assign mac_if.ia_row_mem_data     = skid_full_q ? skid_ia_q : (pend_q ? ia_rd_data : '0);
    assign mac_if.weight_row_mem_data = skid_full_q ? skid_wt_q : (pend_q ? wt_rd_data : '0);

`ifdef MAC_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles the MAC holds off a valid beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (head_valid && !mac_if.mac_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mac_operand_feeder.md
MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter INPUT_BW, default 8, operand width.
REQ-002 SHALL have parameter ADDR_W, default 10, row-memory address width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports start (input, 1) and done (output, 1); done is a one-cycle completion pulse.
REQ-006 SHALL have config ports K (input, 3), IMG_H (input, 6), IMG_W (input, 6), OC (input, 8) and STRIDE (input, 3), sampled only on accepted start.
REQ-007 SHALL have ports ia_rd_en (output, 1), ia_rd_addr (output, ADDR_W) and ia_rd_data (input, INPUT_BW, signed) to the activation row memory.
REQ-008 SHALL have ports wt_rd_en (output, 1), wt_rd_addr (output, ADDR_W) and wt_rd_data (input, INPUT_BW, signed) to the weight row memory.
REQ-009 SHALL have ports ia_row_mem_data and weight_row_mem_data (output, INPUT_BW, signed), the operands driven to mac.
REQ-010 SHALL have ports op_valid, op_first, op_last (output, 1 each) and mac_ready (input, 1).
REQ-011 SHALL have ports busy and cfg_err (output, 1 each).

Function
REQ-012 Both memories SHALL be treated as having a fixed read latency of 1 cycle: rd_data is valid the cycle after rd_en.
REQ-013 OH SHALL be (IMG_H-K)/STRIDE+1 and OW SHALL be (IMG_W-K)/STRIDE+1, using integer division.
REQ-014 Loop order SHALL be oc outer, then oy, ox, ky, with kx innermost; total beats SHALL be OC*OH*OW*K*K.
REQ-015 ia_rd_addr SHALL be (oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx, and wt_rd_addr SHALL be oc*K*K + ky*K + kx; results SHALL be truncated to ADDR_W.
REQ-016 FSM states SHALL be IDLE, CHECK, RUN, DRAIN and DONE.
REQ-017 IDLE SHALL move to CHECK on start; start SHALL be ignored in every state except IDLE.
REQ-018 CHECK SHALL move to DONE and assert cfg_err if K=0, STRIDE=0, OC=0, K>IMG_H or K>IMG_W; otherwise it SHALL move to RUN.
REQ-019 In RUN, one read pair SHALL be issued per cycle while the skid buffer is empty or mac_ready=1.
REQ-020 After the last read, RUN SHALL move to DRAIN; DRAIN SHALL move to DONE when the last beat is accepted.
REQ-021 DONE SHALL pulse done for 1 cycle and then return to IDLE.
REQ-022 A beat SHALL transfer only when op_valid=1 and mac_ready=1.
REQ-023 While op_valid=1 and mac_ready=0, the operand outputs, op_first and op_last SHALL hold stable.
REQ-024 A read issued in the cycle mac_ready falls SHALL be captured in a 1-entry skid buffer; no beat SHALL be lost or duplicated.
REQ-025 op_first SHALL be 1 on the beat with ky=kx=0; op_last SHALL be 1 on the beat with ky=kx=K-1, marking one output pixel.
REQ-026 Latency: start accepted at cycle T SHALL give first rd_en at T+2 and first op_valid at T+3, with no stalls.
REQ-027 Stall-free throughput SHALL be 1 beat per cycle.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 cfg_err SHALL be 1 only in the DONE cycle of a rejected configuration.
REQ-030 rd_en SHALL never assert after a rejected configuration.

Reset
REQ-031 Reset SHALL asynchronously force IDLE and clear all counters and the skid buffer.
REQ-032 Reset SHALL drive all outputs to 0, including addresses and operands.
REQ-033 Reset during RUN or DRAIN SHALL abort the job with no done pulse.
REQ-034 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-035 Macro MAC_FEEDER_STALL_CNT_EN SHALL gate the stall-counter feature.
REQ-036 With MAC_FEEDER_STALL_CNT_EN defined, the block SHALL add output stall_cnt[15:0], counting cycles with op_valid=1 and mac_ready=0, saturating at 16'hFFFF, cleared on accepted start and by reset.
REQ-037 Without MAC_FEEDER_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 K=3, IMG 4x4, STRIDE=1, OC=1, mac_ready=1 -> 36 beats; first 9 ia addresses 0,1,2,4,5,6,8,9,10 and wt addresses 0..8; op_last on beats 9, 18, 27 and 36; done 1 cycle after beat 36.
REQ-039 K=3, IMG 5x5, STRIDE=2, OC=2 -> 72 beats; pixel (oy=1, ox=1) starts at ia address 12; oc=1 starts at wt address 9.
REQ-040 As REQ-038 with mac_ready low for 3 cycles at beat 5 -> operands frozen during the stall; beat sequence identical to the no-stall run; stall_cnt=3 when the macro is defined.
REQ-041 start with K=4, IMG 3x3 -> no rd_en; done and cfg_err high in the same single cycle, 2 cycles after start.
REQ-042 reset asserted at beat 10 of REQ-038 -> outputs 0 immediately, no done; a new start then yields the full 36-beat sequence.
REQ-043 start pulsed again during RUN -> ignored; beat count and config unchanged.
